alu_issue: RTL and testbench
============================

# alu_issue

Decode/issue stage for the execute-stage ALU. Takes a fetched RV32I instruction, its PC and register-file read data, and generates the 4-bit ALU control code, both ALU operands, immediate and side-band control. Results are registered into the decode→execute pipeline register with a valid/ready handshake, stall and flush. Sits directly upstream of the ALU, producing every input that block consumes.

## Interface
- `DATA_WIDTH`, 32, operand/PC width
- `OP_WIDTH`, 4, ALU control width
- `iClk`  in  1  clock, all state on rising edge
- `iRst`  in  1  reset, synchronous, active-high
- `iValid`  in  1  upstream instruction valid
- `oReady`  out  1  stage can accept; combinational: `!oValid || iReady`
- `iInstr`  in  32  instruction word
- `iPc`  in  DATA_WIDTH  instruction address
- `iRs1Data`, `iRs2Data`  in  DATA_WIDTH  register-file read data
- `iFlush`  in  1  kill register contents (branch redirect)
- `oValid`  out  1  registered instruction valid to execute
- `iReady`  in  1  execute accepts (0 = stall)
- `oAluControl`  out  OP_WIDTH  0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and
- `oAluOp1`, `oAluOp2`  out  DATA_WIDTH  ALU operands
- `oImm`  out  DATA_WIDTH  sign-extended immediate (branch/jump target adders)
- `oStoreData`, `oPc`  out  DATA_WIDTH  rs2 data for stores; instruction PC
- `oRd`  out  5  destination register
- `oRegWrite`, `oMemRead`, `oMemWrite`, `oJump`, `oJalr`, `oBranch`  out  1 each
- `oBranchOnZero`  out  1  branch taken when ALU zero flag = 1 (else when 0)
- `oFunct3`  out  3  load/store size and sign
- `oIllegal`  out  1  only with `ALU_ISSUE_ILLEGAL_EN`

## Operation
- Register load condition: `iValid && oReady`. The registered fields capture the decode of `iInstr`.
- OP (0110011): funct3/funct7[5] select add/sub, sll, slt, sltu, xor, srl/sra, or, and. Op1 = rs1 and Op2 = rs2, with Op2 masked to bits [4:0] for shifts.
- OP-IMM (0010011): same mapping; funct7[5] is honoured only for srai. Op2 = imm. For slli/srli/srai, Op2 = {27'b0, instr[24:20]}, so the 0x400 in srai does not reach the ALU.
- LUI: add, Op1 = 0, Op2 = U-imm.
- AUIPC: add, Op1 = PC, Op2 = U-imm.
- LOAD/STORE: add, Op1 = rs1, Op2 = I-/S-imm. Set oMemRead/oMemWrite.
- JAL/JALR: add, Op1 = PC, Op2 = 4 (link value). oImm = J-/I-imm. Set oJump, plus oJalr for JALR.
- BRANCH: beq/bne → sub; blt/bge → slt; bltu/bgeu → sltu. oBranchOnZero = 1 for beq, bge, bgeu.
- oRegWrite = 0 for STORE/BRANCH and whenever rd = x0.
- Unrecognised encodings follow the Configuration section.

## Timing
- Latency: 1 cycle, input accept → oValid.
- Reset: oValid = 0 and every other output = 0, including oAluControl = 0000.
- Stall (`oValid && !iReady`): all outputs hold; oReady = 0.
- iValid with oReady = 0: the instruction is not taken. Upstream must hold it.
- Flush: oValid = 0 next cycle and the instruction presented that cycle is dropped. Flush dominates load and stall.
- Reset asserted mid-stall or with iFlush: reset wins. The clear completes in one cycle.
- Back-to-back: with iReady held high, one instruction is issued per cycle.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined: `oIllegal` exists. An illegal encoding registers with oValid = 1, oIllegal = 1, and oRegWrite/oMemRead/oMemWrite/oJump/oBranch = 0. Illegal encodings are: unknown opcode; OP funct7 ∉ {0x00, 0x20}; 0x20 on non-sub/sra; bad shift-imm bits [31:25]; branch funct3 010/011; load funct3 011/110/111; store funct3 ≥ 011.
- Undefined: no oIllegal port. Illegal encodings issue as add with all enables 0, which behaves as a NOP.

## Structure
- `alu_pkg`: enum `alu_op_e` for the ten ALU codes; opcode localparams; funct3 constants.
- Sub-module `imm_gen`: combinational I/S/B/U/J sign-extension from `iInstr`.

## Test plan
- `add x3,x1,x2` with rs1 = 5, rs2 = 7 → next cycle oValid = 1, oAluControl = 0000, Op1 = 5, Op2 = 7, oRd = 3, oRegWrite = 1.
- `srai x1,x2,4` with rs2 data = 0xFFFF0000 → oAluControl = 0111, Op2 = 4, Op1 = rs1 data.
- `bge` → oAluControl = 0011, oBranch = 1, oBranchOnZero = 1. `bne` → 0001, oBranchOnZero = 0.
- iReady = 0 for 3 cycles while iValid = 1 → outputs frozen, oReady = 0. On iReady = 1 the held instruction is accepted next cycle, with no loss or duplication.
- iFlush with iValid in the same cycle → next cycle oValid = 0. iRst mid-stall → all outputs 0.
- Opcode 0x7F with the macro defined → oIllegal = 1 and all enables 0. Without the macro → add, all enables 0.

Source files
------------

// File: rtl/alu_pkg.sv
// +------------------------------------------------------------------------+
// | alu_pkg: ALU control codes, RV32I opcode/funct constants, decode types |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    jump;
        logic    jalr;
        logic    branch;
        logic    branch_on_zero;
    } ctrl_t;

    // OP / OP-IMM arithmetic mapping; alt selects sub/sra where applicable
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// +------------------------------------------------------------------------+
// | imm_gen: combinational I/S/B/U/J immediate sign-extension              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module imm_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:7]           iInstr,
    output logic [DATA_WIDTH-1:0] oImmI,
    output logic [DATA_WIDTH-1:0] oImmS,
    output logic [DATA_WIDTH-1:0] oImmB,
    output logic [DATA_WIDTH-1:0] oImmU,
    output logic [DATA_WIDTH-1:0] oImmJ
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{iInstr[31]}}, iInstr[31:20]};
    assign imm_s = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
    assign imm_b = {{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25], iInstr[11:8], 1'b0};
    assign imm_u = {iInstr[31:12], 12'h000};
    assign imm_j = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20], iInstr[30:21], 1'b0};

    // Widen to the datapath width keeping the sign
    assign oImmI = DATA_WIDTH'($signed(imm_i));
    assign oImmS = DATA_WIDTH'($signed(imm_s));
    assign oImmB = DATA_WIDTH'($signed(imm_b));
    assign oImmU = DATA_WIDTH'($signed(imm_u));
    assign oImmJ = DATA_WIDTH'($signed(imm_j));

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// +------------------------------------------------------------------------+
// | alu_issue: RV32I decode/issue into the decode->execute register        |
// | Optional: ALU_ISSUE_ILLEGAL_EN adds the oIllegal output.               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [31:0]           iInstr,
    input  logic [DATA_WIDTH-1:0] iPc,
    input  logic [DATA_WIDTH-1:0] iRs1Data,
    input  logic [DATA_WIDTH-1:0] iRs2Data,
    input  logic                  iFlush,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [OP_WIDTH-1:0]   oAluControl,
    output logic [DATA_WIDTH-1:0] oAluOp1,
    output logic [DATA_WIDTH-1:0] oAluOp2,
    output logic [DATA_WIDTH-1:0] oImm,
    output logic [DATA_WIDTH-1:0] oStoreData,
    output logic [DATA_WIDTH-1:0] oPc,
    output logic [4:0]            oRd,
    output logic                  oRegWrite,
    output logic                  oMemRead,
    output logic                  oMemWrite,
    output logic                  oJump,
    output logic                  oJalr,
    output logic                  oBranch,
    output logic                  oBranchOnZero,
    output logic [2:0]            oFunct3
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic                  oIllegal
`endif
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_shift;
    logic       load_en;

    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [DATA_WIDTH-1:0] shamt;

    ctrl_t                 ctrl_d, ctrl_q;
    logic                  illegal_d;
    logic [DATA_WIDTH-1:0] op1_d, op2_d, imm_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] op1_q, op2_q, imm_q, store_q, pc_q;
    logic [4:0]            rd_q;
    logic [2:0]            funct3_q;

    assign opcode   = iInstr[6:0];
    assign funct3   = iInstr[14:12];
    assign funct7   = iInstr[31:25];
    assign rd       = iInstr[11:7];
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    assign shamt    = DATA_WIDTH'(iInstr[24:20]);

    assign oReady  = !valid_q || iReady;
    assign load_en = iValid && oReady;

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .iInstr (iInstr[31:7]),
        .oImmI  (imm_i),
        .oImmS  (imm_s),
        .oImmB  (imm_b),
        .oImmU  (imm_u),
        .oImmJ  (imm_j)
    );

    always_comb begin
        ctrl_d        = '0;
        ctrl_d.alu_op = ALU_ADD;
        illegal_d     = 1'b0;
        op1_d         = '0;
        op2_d         = '0;
        imm_d         = '0;
        case (opcode)
            OPC_OP: begin
                ctrl_d.alu_op    = arith_op(funct3, funct7[5]);
                ctrl_d.reg_write = 1'b1;
                op1_d            = iRs1Data;
                op2_d            = is_shift ? DATA_WIDTH'(iRs2Data[4:0]) : iRs2Data;
                illegal_d        = !((funct7 == F7_BASE) ||
                                     ((funct7 == F7_ALT) &&
                                      ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));
            end
            OPC_OP_IMM: begin
                // addi has no subtract form; only srai uses the alternate bit
                ctrl_d.alu_op    = arith_op(funct3, (funct3 == F3_SRL_SRA) && funct7[5]);
                ctrl_d.reg_write = 1'b1;
                op1_d            = iRs1Data;
                op2_d            = is_shift ? shamt : imm_i;
                imm_d            = imm_i;
                if (funct3 == F3_SLL) begin
                    illegal_d = (funct7 != F7_BASE);
                end else if (funct3 == F3_SRL_SRA) begin
                    illegal_d = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
            end
            OPC_LUI: begin
                ctrl_d.reg_write = 1'b1;
                op2_d            = imm_u;
                imm_d            = imm_u;
            end
            OPC_AUIPC: begin
                ctrl_d.reg_write = 1'b1;
                op1_d            = iPc;
                op2_d            = imm_u;
                imm_d            = imm_u;
            end
            OPC_LOAD: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.mem_read  = 1'b1;
                op1_d            = iRs1Data;
                op2_d            = imm_i;
                imm_d            = imm_i;
                illegal_d        = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                ctrl_d.mem_write = 1'b1;
                op1_d            = iRs1Data;
                op2_d            = imm_s;
                imm_d            = imm_s;
                illegal_d        = (funct3 >= 3'b011);
            end
            OPC_JAL, OPC_JALR: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.jump      = 1'b1;
                ctrl_d.jalr      = (opcode == OPC_JALR);
                op1_d            = iPc;
                op2_d            = DATA_WIDTH'(4);
                imm_d            = (opcode == OPC_JALR) ? imm_i : imm_j;
            end
            OPC_BRANCH: begin
                case (funct3)
                    F3_BEQ, F3_BNE: ctrl_d.alu_op = ALU_SUB;
                    F3_BLT, F3_BGE: ctrl_d.alu_op = ALU_SLT;
                    default:        ctrl_d.alu_op = ALU_SLTU;
                endcase
                ctrl_d.branch         = 1'b1;
                ctrl_d.branch_on_zero = (funct3 == F3_BEQ) || (funct3 == F3_BGE) ||
                                        (funct3 == F3_BGEU);
                op1_d                 = iRs1Data;
                op2_d                 = iRs2Data;
                imm_d                 = imm_b;
                illegal_d             = (funct3[2:1] == 2'b01);
            end
            default: illegal_d = 1'b1;
        endcase

        // Illegal encodings degrade to an add with every side effect removed
        if (illegal_d) begin
            ctrl_d        = '0;
            ctrl_d.alu_op = ALU_ADD;
            op1_d         = '0;
            op2_d         = '0;
            imm_d         = '0;
        end
        if (rd == 5'd0) begin
            ctrl_d.reg_write = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            valid_q       <= 1'b0;
            ctrl_q        <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            imm_q         <= '0;
            store_q       <= '0;
            pc_q          <= '0;
            rd_q          <= '0;
            funct3_q      <= '0;
        end else begin
            if (iFlush) begin
                valid_q <= 1'b0;
            end else if (load_en) begin
                valid_q <= 1'b1;
            end else if (iReady) begin
                valid_q <= 1'b0;
            end
            if (load_en && !iFlush) begin
                ctrl_q   <= ctrl_d;
                op1_q    <= op1_d;
                op2_q    <= op2_d;
                imm_q    <= imm_d;
                store_q  <= iRs2Data;
                pc_q     <= iPc;
                rd_q     <= rd;
                funct3_q <= funct3;
            end
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            illegal_q <= 1'b0;
        end else if (load_en && !iFlush) begin
            illegal_q <= illegal_d;
        end
    end

    assign oIllegal = illegal_q;
`endif

    assign oValid        = valid_q;
    assign oAluControl   = OP_WIDTH'(ctrl_q.alu_op);
    assign oAluOp1       = op1_q;
    assign oAluOp2       = op2_q;
    assign oImm          = imm_q;
    assign oStoreData    = store_q;
    assign oPc           = pc_q;
    assign oRd           = rd_q;
    assign oRegWrite     = ctrl_q.reg_write;
    assign oMemRead      = ctrl_q.mem_read;
    assign oMemWrite     = ctrl_q.mem_write;
    assign oJump         = ctrl_q.jump;
    assign oJalr         = ctrl_q.jalr;
    assign oBranch       = ctrl_q.branch;
    assign oBranchOnZero = ctrl_q.branch_on_zero;
    assign oFunct3       = funct3_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// +------------------------------------------------------------------------+
// | tb_alu_issue: scoreboard bench for alu_issue with a reference decoder  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] instr, pc, rs1, rs2;
    logic        ready_o, valid_o;
    logic [3:0]  alu_ctl;
    logic [31:0] op1, op2, imm, sdata, pc_o;
    logic [4:0]  rd_o;
    logic        rw, mr, mw, jmp, jlr, br, boz;
    logic [2:0]  f3_o;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        ill_o;
`endif

    always #5 clk = ~clk;

    alu_issue #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .iClk(clk), .iRst(rst), .iValid(in_valid), .oReady(ready_o),
        .iInstr(instr), .iPc(pc), .iRs1Data(rs1), .iRs2Data(rs2),
        .iFlush(flush), .oValid(valid_o), .iReady(out_ready),
        .oAluControl(alu_ctl), .oAluOp1(op1), .oAluOp2(op2), .oImm(imm),
        .oStoreData(sdata), .oPc(pc_o), .oRd(rd_o), .oRegWrite(rw),
        .oMemRead(mr), .oMemWrite(mw), .oJump(jmp), .oJalr(jlr),
        .oBranch(br), .oBranchOnZero(boz), .oFunct3(f3_o)
`ifdef ALU_ISSUE_ILLEGAL_EN
        , .oIllegal(ill_o)
`endif
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] op1, op2, imm, sd, pc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, mr, mw, j, jr, br, boz, ill;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_rst = 1'b0;

    // ALU code for each funct3 of the register/immediate arithmetic group
    logic [3:0] arith_tab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] ipc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          f3, f7;
        bit          legal, wr;
        logic [31:0] ii, si, bi, ui, ji;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        ii = 32'($signed(ins[31:20]));
        si = 32'($signed({ins[31:25], ins[11:7]}));
        bi = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        ui = {ins[31:12], 12'h000};
        ji = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e = '{default: '0};
        e.pc = ipc; e.sd = b; e.rd = ins[11:7]; e.f3 = ins[14:12];
        legal = 1; wr = 0;
        case (ins[6:0])
            7'h33: begin
                e.ctrl = arith_tab[f3];
                if (f7 == 32 && f3 == 0) e.ctrl = 4'd1;
                if (f7 == 32 && f3 == 5) e.ctrl = 4'd7;
                legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.op1 = a;
                e.op2 = (f3 == 1 || f3 == 5) ? (b % 32) : b;
                wr = 1;
            end
            7'h13: begin
                e.ctrl = arith_tab[f3];
                if (f3 == 5 && ins[30]) e.ctrl = 4'd7;
                e.op1 = a; e.imm = ii; e.op2 = ii;
                if (f3 == 1) begin e.op2 = 32'(ins[24:20]); legal = (f7 == 0); end
                if (f3 == 5) begin e.op2 = 32'(ins[24:20]); legal = (f7 == 0 || f7 == 32); end
                wr = 1;
            end
            7'h37: begin e.op2 = ui; e.imm = ui; wr = 1; end
            7'h17: begin e.op1 = ipc; e.op2 = ui; e.imm = ui; wr = 1; end
            7'h03: begin
                e.op1 = a; e.op2 = ii; e.imm = ii; e.mr = 1; wr = 1;
                legal = !(f3 == 3 || f3 == 6 || f3 == 7);
            end
            7'h23: begin e.op1 = a; e.op2 = si; e.imm = si; e.mw = 1; legal = (f3 < 3); end
            7'h6F: begin e.op1 = ipc; e.op2 = 4; e.imm = ji; e.j = 1; wr = 1; end
            7'h67: begin e.op1 = ipc; e.op2 = 4; e.imm = ii; e.j = 1; e.jr = 1; wr = 1; end
            7'h63: begin
                e.op1 = a; e.op2 = b; e.imm = bi; e.br = 1;
                e.ctrl = (f3 < 2) ? 4'd1 : (f3 >= 6) ? 4'd4 : 4'd3;
                e.boz = (f3 == 0 || f3 == 5 || f3 == 7);
                legal = !(f3 == 2 || f3 == 3);
            end
            default: legal = 0;
        endcase
        e.rw = wr && (ins[11:7] != 0);
        if (!legal) begin
            e.ctrl = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.j = 0; e.jr = 0;
            e.br = 0; e.boz = 0; e.ill = 1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks the registered stage against the scoreboard mid-cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (prev_rst) begin
            chk("rst_valid", 32'(valid_o), 0);
            chk("rst_ctl", 32'(alu_ctl), 0);
            chk("rst_ops", op1 | op2 | imm | sdata | pc_o, 0);
            chk("rst_misc", {rd_o, f3_o, rw, mr, mw, jmp, jlr, br, boz}, 0);
        end
        chk("ready", 32'(ready_o), 32'(!valid_o || out_ready));
        chk("valid", 32'(valid_o), 32'(q.size() > 0));
        if (valid_o && q.size() > 0) begin
            e = q[0];
            chk("alu_ctl", 32'(alu_ctl), 32'(e.ctrl));
            chk("enables", {rw, mr, mw, jmp, jlr, br, boz},
                {e.rw, e.mr, e.mw, e.j, e.jr, e.br, e.boz});
            chk("store_pc_rd_f3", sdata ^ pc_o ^ {rd_o, f3_o}, e.sd ^ e.pc ^ {e.rd, e.f3});
            if (!e.ill) begin
                chk("op1", op1, e.op1);
                chk("op2", op2, e.op2);
                chk("imm", imm, e.imm);
            end
`ifdef ALU_ISSUE_ILLEGAL_EN
            chk("illegal", 32'(ill_o), 32'(e.ill));
`endif
            if (out_ready || flush) void'(q.pop_front());
        end
        prev_rst = rst;
    end

    // One clock of stimulus; the expected response is queued on acceptance
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] ipc,
                        input logic [31:0] a, input logic [31:0] b, input logic rdy,
                        input logic fl, input logic rs, output logic acc);
        bit busy;
        @(posedge clk); #1;
        busy = (q.size() > 0);
        in_valid = v; instr = ins; pc = ipc; rs1 = a; rs2 = b;
        out_ready = rdy; flush = fl; rst = rs;
        acc = !rs && v && !fl && (!busy || rdy);
        @(negedge clk); #1;
        if (rs) q.delete();
        else if (acc) q.push_back(model(ins, ipc, a, b));
    endtask

    function automatic logic [31:0] gen();
        logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63};
        logic [6:0]  bad  [5] = '{7'h7F, 7'h0B, 7'h2B, 7'h5B, 7'h77};
        logic [31:0] ins;
        int          k;
        k = $urandom_range(0, 9);
        ins = $urandom;
        ins[6:0] = (k == 9) ? bad[$urandom_range(0, 4)] : opcs[k];
        if (k <= 1 && $urandom_range(0, 7) != 0) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    logic        acc;
    logic [31:0] cur;
    logic        pend;

    initial begin
        in_valid = 0; instr = 0; pc = 0; rs1 = 0; rs2 = 0;
        out_ready = 1; flush = 0; rst = 1;
        step(0, 0, 0, 0, 0, 1, 0, 1, acc);
        step(0, 0, 0, 0, 0, 1, 0, 1, acc);
        step(0, 0, 0, 0, 0, 1, 0, 0, acc);

        // add x3,x1,x2 ; srai x1,x2,4 ; bge ; bne
        step(1, 32'h002081B3, 32'h100, 5, 7, 1, 0, 0, acc);
        step(1, 32'h40415093, 32'h104, 32'hFFFF0000, 32'h0, 1, 0, 0, acc);
        step(1, 32'h0020D463, 32'h108, 1, 2, 1, 0, 0, acc);
        step(1, 32'h00209463, 32'h10C, 1, 2, 1, 0, 0, acc);
        step(0, 0, 0, 0, 0, 1, 0, 0, acc);

        // Three-cycle stall with a waiting instruction, then release
        step(1, 32'h00A00513, 32'h200, 0, 0, 1, 0, 0, acc);
        for (int i = 0; i < 3; i++) step(1, 32'h00B00593, 32'h204, 0, 0, 0, 0, 0, acc);
        step(1, 32'h00B00593, 32'h204, 0, 0, 1, 0, 0, acc);
        step(0, 0, 0, 0, 0, 1, 0, 0, acc);
        step(0, 0, 0, 0, 0, 1, 0, 0, acc);

        // Flush alongside a new instruction, then reset in the middle of a stall
        step(1, 32'h00C00613, 32'h300, 0, 0, 1, 1, 0, acc);
        step(0, 0, 0, 0, 0, 1, 0, 0, acc);
        step(1, 32'h00D00693, 32'h304, 0, 0, 1, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, acc);
        step(0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 1, 0, 0, acc);

        // Unknown opcode 0x7F
        step(1, 32'h000001FF, 32'h400, 9, 9, 1, 0, 0, acc);
        step(0, 0, 0, 0, 0, 1, 0, 0, acc);

        pend = 0; cur = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend) cur = gen();
            step($urandom_range(0, 3) != 0, cur, $urandom & 32'hFFFFFFFC, $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 199) == 0, acc);
            pend = in_valid && !acc && !flush && !rst;
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0, 0, acc);
        chk("drain", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
